// File: rtl/wbck_arbiter_pkg.sv
// Shared constants and helpers for the write-back arbiter and scoreboard.
package wbck_arbiter_pkg;

    localparam int WB_ALU    = 0;
    localparam int WB_MULDIV = 1;
    localparam int WB_LSU    = 2;
    localparam int WB_NREQ   = 3;
    localparam int REG_AW    = 5;
    localparam int REG_DW    = 32;
    localparam int NREG      = 32;

    // Round-robin pick: first valid requester at or above ptr, wrapping.
    function automatic logic [WB_NREQ-1:0] rr_pick(
        input logic [WB_NREQ-1:0] valid,
        input logic [1:0]         ptr
    );
        logic [WB_NREQ-1:0] g;
        logic [1:0]         k;
        g = '0;
        for (int i = 0; i < WB_NREQ; i++) begin
            k = 2'((int'(ptr) + i) % WB_NREQ);
            if (g == '0 && valid[k]) begin
                g[k] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/wbck_scoreboard.sv
// Per-register pending scoreboard for long-latency write-backs,
// with same-cycle-clear masked hazard lookups.
module wbck_scoreboard
    import wbck_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en_i,
    input  logic [REG_AW-1:0] set_idx_i,
    input  logic              clr_en_i,
    input  logic [REG_AW-1:0] clr_idx_i,
    input  logic [REG_AW-1:0] src1_idx_i,
    input  logic [REG_AW-1:0] src2_idx_i,
    input  logic [REG_AW-1:0] dest_idx_i,
    output logic              hz_src1_o,
    output logic              hz_src2_o,
    output logic              hz_dest_o
);

    logic [NREG-1:0] pending_q, pending_d;

    // Set is applied after clear so a new owner wins the same-cycle race.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            pending_d[set_idx_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign hz_src1_o = pending_q[src1_idx_i]
                     & ~(clr_en_i && clr_idx_i == src1_idx_i);
    assign hz_src2_o = pending_q[src2_idx_i]
                     & ~(clr_en_i && clr_idx_i == src2_idx_i);
    assign hz_dest_o = pending_q[dest_idx_i]
                     & ~(clr_en_i && clr_idx_i == dest_idx_i);

endmodule

// File: rtl/wbck_arbiter.sv
// Regfile write-back arbiter (ALU, MULDIV, LSU) with pending scoreboard.
// MYRISCV_WBCK_RR_EN selects round-robin; otherwise LSU > MULDIV > ALU.
module wbck_arbiter
    import wbck_arbiter_pkg::*;
#(
    parameter int NREQ = WB_NREQ
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*REG_AW-1:0] req_idx,
    input  logic [NREQ*REG_DW-1:0] req_dat,
    output logic [NREQ-1:0]        req_ready,
    output logic                   wbck_dest_wen,
    output logic [REG_AW-1:0]      wbck_dest_idx,
    output logic [REG_DW-1:0]      wbck_dest_dat,
    input  logic                   disp_valid,
    input  logic                   disp_long,
    input  logic [REG_AW-1:0]      disp_rd,
    input  logic [REG_AW-1:0]      chk_src1_idx,
    input  logic [REG_AW-1:0]      chk_src2_idx,
    output logic                   hz_src1,
    output logic                   hz_src2,
    output logic                   hz_dest
);

    logic [NREQ-1:0] gnt;

`ifdef MYRISCV_WBCK_RR_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        gnt      = rr_pick(req_valid, rr_ptr_q);
        rr_ptr_d = rr_ptr_q;
        unique case (1'b1)
            gnt[WB_ALU]:    rr_ptr_d = 2'd1;
            gnt[WB_MULDIV]: rr_ptr_d = 2'd2;
            gnt[WB_LSU]:    rr_ptr_d = 2'd0;
            default:        rr_ptr_d = rr_ptr_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        gnt = '0;
        priority case (1'b1)
            req_valid[WB_LSU]:    gnt[WB_LSU]    = 1'b1;
            req_valid[WB_MULDIV]: gnt[WB_MULDIV] = 1'b1;
            req_valid[WB_ALU]:    gnt[WB_ALU]    = 1'b1;
            default:              gnt            = '0;
        endcase
    end
`endif

    always_comb begin
        wbck_dest_idx = '0;
        wbck_dest_dat = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                wbck_dest_idx = req_idx[k*REG_AW +: REG_AW];
                wbck_dest_dat = req_dat[k*REG_DW +: REG_DW];
            end
        end
    end

    assign req_ready     = gnt;
    assign wbck_dest_wen = (|gnt) && (wbck_dest_idx != '0);

    // Only long-latency producers own scoreboard entries.
    wbck_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (disp_valid & disp_long),
        .set_idx_i  (disp_rd),
        .clr_en_i   (gnt[WB_MULDIV] | gnt[WB_LSU]),
        .clr_idx_i  (wbck_dest_idx),
        .src1_idx_i (chk_src1_idx),
        .src2_idx_i (chk_src2_idx),
        .dest_idx_i (disp_rd),
        .hz_src1_o  (hz_src1),
        .hz_src2_o  (hz_src2),
        .hz_dest_o  (hz_dest)
    );

endmodule

// File: tb/tb_wbck_arbiter.sv
// Directed plus randomized bench for wbck_arbiter against a behavioural model.
module tb_wbck_arbiter;
    import wbck_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [14:0] req_idx;
    logic [95:0] req_dat;
    logic [2:0]  req_ready;
    logic        wbck_dest_wen;
    logic [4:0]  wbck_dest_idx;
    logic [31:0] wbck_dest_dat;
    logic        disp_valid, disp_long;
    logic [4:0]  disp_rd, chk_src1_idx, chk_src2_idx;
    logic        hz_src1, hz_src2, hz_dest;

    int nvec = 0;
    int nmis = 0;
    bit pend [32];
    int ptr;
    int last_k;

    always #5 clk = ~clk;

    wbck_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_idx       (req_idx),
        .req_dat       (req_dat),
        .req_ready     (req_ready),
        .wbck_dest_wen (wbck_dest_wen),
        .wbck_dest_idx (wbck_dest_idx),
        .wbck_dest_dat (wbck_dest_dat),
        .disp_valid    (disp_valid),
        .disp_long     (disp_long),
        .disp_rd       (disp_rd),
        .chk_src1_idx  (chk_src1_idx),
        .chk_src2_idx  (chk_src2_idx),
        .hz_src1       (hz_src1),
        .hz_src2       (hz_src2),
        .hz_dest       (hz_dest)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner is the valid requester closest to ptr (RR) or the highest index.
    function automatic int pick(input logic [2:0] v);
        int best = -1;
`ifdef MYRISCV_WBCK_RR_EN
        int bd = 99;
        for (int k = 0; k < 3; k++) begin
            if (v[k] && ((k - ptr + 3) % 3) < bd) begin
                bd   = (k - ptr + 3) % 3;
                best = k;
            end
        end
`else
        for (int k = 0; k < 3; k++) begin
            if (v[k]) best = k;
        end
`endif
        return best;
    endfunction

    function automatic logic hz_exp(input logic [4:0] i, input logic clr,
                                    input logic [4:0] ci);
        return (i != 0) && pend[i] && !(clr && ci == i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        ptr = 0;
    endtask

    // Called at a negedge: check all outputs, then advance model at posedge.
    task automatic eval_step();
        int          k;
        logic [4:0]  gi;
        logic [31:0] gd;
        logic        clr;
        k  = pick(req_valid);
        gi = '0;
        gd = '0;
        if (k >= 0) begin
            gi = req_idx[k*5 +: 5];
            gd = req_dat[k*32 +: 32];
        end
        clr = (k == 1 || k == 2) && gi != 0;
        chk("ready", 32'(req_ready), (k >= 0) ? (32'd1 << k) : 32'd0);
        chk("wen", 32'(wbck_dest_wen), 32'(k >= 0 && gi != 0));
        chk("idx", 32'(wbck_dest_idx), 32'(gi));
        chk("dat", wbck_dest_dat, gd);
        chk("hz1", 32'(hz_src1), 32'(hz_exp(chk_src1_idx, clr, gi)));
        chk("hz2", 32'(hz_src2), 32'(hz_exp(chk_src2_idx, clr, gi)));
        chk("hzd", 32'(hz_dest), 32'(hz_exp(disp_rd, clr, gi)));
        last_k = k;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (clr) pend[gi] = 1'b0;
            if (disp_valid && disp_long && disp_rd != 0) pend[disp_rd] = 1'b1;
            if (k >= 0) ptr = (k + 1) % 3;
        end
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        eval_step();
    endtask

    initial begin
        logic [2:0] ord [6];
`ifdef MYRISCV_WBCK_RR_EN
        ord = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        ord = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
`endif
        model_reset();
        last_k       = -1;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_idx      = '0;
        req_dat      = '0;
        disp_valid   = 1'b0;
        disp_long    = 1'b0;
        disp_rd      = '0;
        chk_src1_idx = '0;
        chk_src2_idx = '0;
        cycle();
        cycle();
        rst_n = 1'b1;

        // All three continuously valid, fresh data after each grant.
        req_valid = 3'b111;
        req_idx   = {5'd3, 5'd2, 5'd1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("order", 32'(req_ready), 32'(ord[i]));
            eval_step();
            req_dat[last_k*32 +: 32] = $urandom;
        end

        req_valid = 3'b010;
        req_idx   = {5'd0, 5'd5, 5'd0};
        req_dat   = {32'd0, 32'h1234, 32'd0};
        @(negedge clk);
        chk("md_ready", 32'(req_ready), 32'b010);
        chk("md_wen", 32'(wbck_dest_wen), 32'd1);
        chk("md_idx", 32'(wbck_dest_idx), 32'd5);
        chk("md_dat", wbck_dest_dat, 32'h1234);
        eval_step();
        req_valid = 3'b011;
        req_idx   = {5'd0, 5'd6, 5'd6};
        @(negedge clk);
`ifdef MYRISCV_WBCK_RR_EN
        chk("ptr2", 32'(req_ready), 32'b001);
`else
        chk("prio", 32'(req_ready), 32'b010);
`endif
        eval_step();
        req_valid = '0;

        disp_valid = 1'b1;
        disp_long  = 1'b1;
        disp_rd    = 5'd7;
        cycle();
        disp_valid   = 1'b0;
        chk_src1_idx = 5'd7;
        @(negedge clk);
        chk("hz7_set", 32'(hz_src1), 32'd1);
        eval_step();
        req_valid = 3'b100;
        req_idx   = {5'd7, 5'd0, 5'd0};
        req_dat   = {32'hcafe, 64'd0};
        @(negedge clk);
        chk("hz7_fwd", 32'(hz_src1), 32'd0);
        eval_step();
        req_valid = '0;
        @(negedge clk);
        chk("hz7_clr", 32'(hz_src1), 32'd0);
        eval_step();

        req_valid    = 3'b100;
        req_idx      = {5'd9, 5'd0, 5'd0};
        disp_valid   = 1'b1;
        disp_rd      = 5'd9;
        chk_src1_idx = 5'd9;
        cycle();
        req_valid  = '0;
        disp_valid = 1'b0;
        @(negedge clk);
        chk("set_wins", 32'(hz_src1), 32'd1);
        eval_step();

        req_valid  = 3'b001;
        req_idx    = '0;
        disp_valid = 1'b1;
        disp_rd    = 5'd0;
        @(negedge clk);
        chk("x0_ready", 32'(req_ready), 32'b001);
        chk("x0_wen", 32'(wbck_dest_wen), 32'd0);
        chk("x0_hzd", 32'(hz_dest), 32'd0);
        eval_step();
        req_valid    = '0;
        disp_valid   = 1'b0;
        chk_src1_idx = 5'd0;
        cycle();

        // Random traffic; requesters hold until granted.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (!req_valid[k] || last_k == k) begin
                    req_valid[k]      = 1'($urandom_range(0, 1));
                    req_idx[k*5 +: 5] = 5'($urandom_range(0, 9));
                    req_dat[k*32 +: 32] = $urandom;
                end
            end
            disp_valid   = 1'($urandom_range(0, 1));
            disp_long    = 1'($urandom_range(0, 1));
            disp_rd      = 5'($urandom_range(0, 9));
            chk_src1_idx = 5'($urandom_range(0, 9));
            chk_src2_idx = 5'($urandom_range(0, 9));
            cycle();
        end

        req_valid    = '0;
        disp_valid   = 1'b1;
        disp_long    = 1'b1;
        disp_rd      = 5'd4;
        cycle();
        disp_valid   = 1'b0;
        chk_src1_idx = 5'd4;
        @(negedge clk);
        chk("hz4_pre", 32'(hz_src1), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_hz4", 32'(hz_src1), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
